// File: rtl/imem_loader_defs.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encodings, default frame sync byte and frame field sizes.
package imem_loader_defs;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    // Frame layout
    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         LEN_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;

    // A frame is in progress in every state between the sync byte and the checksum
    function automatic logic st_busy(input logic [2:0] s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer. The first three bytes of a word are
// held in a register. The fourth byte is merged combinationally so that the
// full word is available in the same cycle as word_ready_o.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  idx_q;
    logic [23:0] word_q;

    // Byte lane capture and byte index; clear restarts at lane 0
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            idx_q  <= 2'd0;
            word_q <= 24'd0;
        end else if (byte_valid_i) begin
            case (idx_q)
                2'd0:    word_q[7:0]   <= byte_i;
                2'd1:    word_q[15:8]  <= byte_i;
                2'd2:    word_q[23:16] <= byte_i;
                default: ;
            endcase
            idx_q <= idx_q + 2'd1;
        end
    end

    assign idx_o        = idx_q;
    assign word_o       = {byte_i, word_q};
    assign word_ready_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time imem writer: parses SYNC/LEN/DATA/CHECKSUM frames from the UART,
// writes packed words into imem and holds the CPU in reset until a frame has
// been written and its checksum verified.
module imem_loader
    import imem_loader_defs::*;
#(
    parameter int         DEPTH   = 256,
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        write,
    output logic [31:0] addr_in,
    output logic [31:0] data,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   widx_q, widx_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          cpu_reset_q, busy_q, done_q, error_q;

    logic          pk_clear, pk_valid, pk_ready;
    logic [1:0]    pk_idx;
    logic [31:0]   pk_word;
    logic [15:0]   n_words;

    assign pk_valid = rx_valid && (state_q == ST_DATA);

    word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_data),
        .idx_o        (pk_idx),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

    // Frame FSM, counters, checksum and idle timeout
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        widx_d   = widx_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        data_d   = data_q;
        write_d  = 1'b0;
        pk_clear = 1'b0;
        n_words  = {rx_data, len_q[7:0]};

        // Idle counter only runs while a frame is open; any byte restarts it
        if (!st_busy(state_q) || rx_valid) tmo_d = '0;
        else                              tmo_d = tmo_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_valid && (rx_data == SYNC)) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_d    = n_words;
                    widx_d   = 16'd0;
                    csum_d   = 8'd0;
                    pk_clear = 1'b1;
                    if ({1'b0, n_words} > DEPTH_W) state_d = ST_ERROR;
                    else if (n_words == 16'd0)     state_d = ST_CHECK;
                    else                           state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_data;
                    if (pk_ready) begin
                        write_d             = 1'b1;
                        addr_d              = 32'd0;
                        addr_d[AW+1:0]      = {widx_q[AW-1:0], 2'b00};
                        data_d              = pk_word;
                        widx_d              = widx_q + 16'd1;
                    end
                    // Last byte of the last word closes the data section
                    if ((pk_idx == 2'd3) && (widx_q == len_q - 16'd1)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase

        if (st_busy(state_q) && !rx_valid && (tmo_d == TW'(TIMEOUT))) state_d = ST_ERROR;
    end

    // State and datapath registers; outputs are registered from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= 16'd0;
            widx_q      <= 16'd0;
            csum_q      <= 8'd0;
            tmo_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_reset_q <= (state_d != ST_DONE);
            busy_q      <= st_busy(state_d);
            done_q      <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERROR);
        end
    end

    assign write     = write_q;
    assign addr_in   = addr_q;
    assign data      = data_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int TMO   = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        write;
    logic [31:0] addr_in;
    logic [31:0] data;
    logic        cpu_reset, busy, done, error;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .SYNC(8'hA5), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .write     (write),
        .addr_in   (addr_in),
        .data      (data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_wr = 0;
    int          wr_base;
    logic [7:0]  csum;
    logic [31:0] nxt_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (write === 1'b1) begin
            wr_t e;
            n_wr++;
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", addr_in, e.addr);
                chk("wr_data", data, e.data);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic hdr(input logic [15:0] n);
        send(8'hA5);
        send(n[7:0]);
        send(n[15:8]);
        csum     = 8'd0;
        nxt_addr = 32'd0;
    endtask

    task automatic word(input logic [31:0] w);
        sb.push_back('{addr: nxt_addr, data: w});
        nxt_addr = nxt_addr + 32'd4;
        for (int i = 0; i < 4; i++) begin
            csum = csum ^ w[8*i +: 8];
            send(w[8*i +: 8]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic cr, input logic bz,
                             input logic dn, input logic er);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        chk({tag, "_busy"},      32'(busy),      32'(bz));
        chk({tag, "_done"},      32'(done),      32'(dn));
        chk({tag, "_error"},     32'(error),     32'(er));
    endtask

    initial begin
        // Reset release
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", addr_in, 32'd0);
        chk("rst_data", data, 32'd0);
        chk_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);

        // Garbage in IDLE is ignored
        send(8'h00);
        send(8'h55);
        chk_flags("garbage", 1'b1, 1'b0, 1'b0, 1'b0);

        // Good two-word frame
        hdr(16'd2);
        chk_flags("a_hdr", 1'b1, 1'b1, 1'b0, 1'b0);
        word(32'h00000113);
        chk("a_write_pulse", 32'(write), 32'd1);
        word(32'h00100093);
        send(8'h91);
        chk_flags("a_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a_write_low", 32'(write), 32'd0);

        // Same frame with a bad checksum
        hdr(16'd2);
        chk_flags("b_hdr", 1'b1, 1'b1, 1'b0, 1'b0);
        word(32'h00000113);
        word(32'h00100093);
        send(8'h00);
        chk_flags("b_err", 1'b1, 1'b0, 1'b0, 1'b1);

        // Recovery with a one-word frame
        send(8'hA5);
        chk_flags("c_sync", 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h01);
        send(8'h00);
        csum     = 8'd0;
        nxt_addr = 32'd0;
        word(32'hDEADBEEF);
        send(csum);
        chk_flags("c_done", 1'b0, 1'b0, 1'b1, 1'b0);

        // Over-length frame: N=257
        hdr(16'd257);
        chk_flags("len_err", 1'b1, 1'b0, 1'b0, 1'b1);

        // Timeout after two data bytes
        hdr(16'd1);
        send(8'h11);
        send(8'h22);
        idle(TMO - 5);
        chk_flags("tmo_wait", 1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);
        chk_flags("tmo_err", 1'b1, 1'b0, 1'b0, 1'b1);

        // Full-depth frame, back-to-back bytes
        wr_base = n_wr;
        hdr(16'd256);
        for (int i = 0; i < 256; i++)
            word({8'(i), 8'(~i), 8'(i * 3), 8'(i ^ 8'h5A)});
        send(csum);
        chk_flags("full_done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_wr_count", 32'(n_wr - wr_base), 32'd256);
        chk("full_last_addr", addr_in, 32'h3FC);

        // Reset in the middle of a repeat run
        hdr(16'd256);
        word(32'h01234567);
        word(32'h89ABCDEF);
        send(8'h01);
        send(8'h02);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_write", 32'(write), 32'd0);
        chk("mid_rst_addr", addr_in, 32'd0);
        chk("mid_rst_data", data, 32'd0);
        chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(5);
        chk_flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: receives a framed byte stream from the UART receiver, packs bytes little-endian into 32-bit words, and drives the imem write port (`write`, `addr_in`, `data`). It sits between the UART RX and imem, and holds the CPU in reset until a complete, checksum-valid image has been written. After a good load it releases the core; a new sync byte restarts loading.

## Interface
Parameters:
- `DEPTH`, 256: imem size in words; maximum accepted word count.
- `SYNC`, 8'hA5: frame start byte.
- `TIMEOUT`, 1_000_000: max idle cycles between bytes inside a frame.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per byte; always accepted, no backpressure.
- `write` out 1: one-cycle imem write strobe.
- `addr_in` out 32: byte address of the word written, word-aligned.
- `data` out 32: word written.
- `cpu_reset` out 1: holds core in reset while high.
- `busy` out 1: frame in progress.
- `done` out 1: last frame loaded and verified.
- `error` out 1: last frame failed (length, checksum, timeout).

## Operation
- Frame: `SYNC`, `LEN_LO`, `LEN_HI` (16-bit word count N), 4·N data bytes (LSB first per word), one checksum byte = XOR of all 4·N data bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE: `rx_valid` with `SYNC` -> LEN_LO; other bytes ignored.
- LEN_LO -> LEN_HI on byte. LEN_HI on byte: N>DEPTH -> ERROR; N=0 -> CHECK; else -> DATA with word index=0, byte index=0, checksum=0.
- DATA: each byte shifts into bits [8·k+7:8·k], k = byte index 0..3; checksum ^= byte. On k=3: word write issued, word index+1; after word N-1 -> CHECK.
- CHECK: byte equal to running checksum -> DONE, else -> ERROR.
- DONE: `cpu_reset`=0, `done`=1. A `SYNC` byte -> LEN_LO, `cpu_reset`=1, `done`=0.
- ERROR: `cpu_reset`=1, `error`=1. A `SYNC` byte -> LEN_LO, `error`=0. Words already written are not rolled back.
- Timeout: counter clears on every accepted byte, counts in LEN_LO, LEN_HI, DATA, CHECK; reaching `TIMEOUT` -> ERROR.
- `busy`=1 in LEN_LO, LEN_HI, DATA, CHECK.
- `addr_in` = word index << 2; bits above log2(DEPTH)+2 are always 0.

## Timing
- Reset values: `write`=0, `addr_in`=0, `data`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0; state IDLE; counters 0.
- `reset` mid-frame aborts immediately to reset values. No partial word is written.
- All outputs are registered. `write` pulses exactly one cycle: the cycle after the 4th byte of a word is accepted. `addr_in` and `data` are valid in that cycle and hold until the next write.
- A byte arriving in the same cycle `write` is high is accepted into the next word. Back-to-back `rx_valid` every cycle is supported with no loss.
- State transitions take effect the cycle after the accepting `rx_valid`. `cpu_reset` falls the cycle after the correct checksum byte. `error` rises the cycle after the failing byte, or the cycle the timeout counter hits `TIMEOUT`.

## Structure
- Shared package/include `imem_loader_defs`: state encodings, `SYNC` default, frame field constants.
- One natural sub-module, `word_packer`: byte strobe in, 2-bit byte index, 32-bit word out plus a `word_ready` pulse. Its clear input is driven by the FSM.
- The FSM, length/word counters, checksum and timeout counter live in the top module.

## Test plan
- Reset release: `cpu_reset`=1, all other outputs 0; garbage bytes 0x00, 0x55 in IDLE -> no state change.
- Frame A5 02 00 | 13 01 00 00 | 93 00 10 00 | checksum 0x91 -> writes (addr 0x0, 0x00000113), (addr 0x4, 0x00100093). `cpu_reset` falls one cycle after the checksum byte; `done`=1.
- Same frame with a bad checksum 0x00 -> `error`=1, `cpu_reset` stays 1; then A5 01 00 + word + good checksum -> recovers to DONE.
- Length A5 01 01 (N=257 > 256) -> ERROR immediately after LEN_HI, no writes.
- Timeout: stop after 2 data bytes, wait `TIMEOUT` cycles -> ERROR, no write pulse.
- Back-to-back bytes on consecutive cycles for N=256 -> 256 writes, last at addr 0x3FC; reset asserted mid-frame in a repeat run -> immediate return to reset values.
